// File: rtl/unidade_entrada.sv
// Input unit: synchronizes and debounces the enter button, stalls the core during an IN
// instruction, and latches the zero-extended switches into SWR on a fresh press.
module unidade_entrada #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int LARGURA_CHAVES  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botao_enter,
    input  logic                      pedido_entrada,
    output logic [31:0]               SWR,
    output logic                      espera,
    output logic                      entrada_valida
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA_SOLTURA,
        AGUARDA_APERTO,
        CONCLUIDO
    } estado_t;

    estado_t estado, prox_estado;

    // Two-stage synchronizers; index 1 is the only stage used downstream.
    logic [1:0][LARGURA_CHAVES-1:0] sinc_chaves;
    logic [1:0]                     sinc_botao;
    logic [LARGURA_CHAVES-1:0]      chaves_s2;
    logic                           botao_s2;

    logic [CW-1:0] contador;
    logic          nivel;
    logic          nivel_ant;
    logic          aperto;
    logic          captura;
    logic [31:0]   chaves_ext;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_chaves <= '0;
            sinc_botao  <= '0;
        end else begin
            sinc_chaves <= {sinc_chaves[0], chaves};
            sinc_botao  <= {sinc_botao[0], botao_enter};
        end
    end

    assign chaves_s2 = sinc_chaves[1];
    assign botao_s2  = sinc_botao[1];

    // The level only flips after DEBOUNCE_CICLOS consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador  <= '0;
            nivel     <= 1'b0;
            nivel_ant <= 1'b0;
        end else begin
            nivel_ant <= nivel;
            if (botao_s2 == nivel) begin
                contador <= '0;
            end else if (contador == LIMITE) begin
                contador <= '0;
                nivel    <= ~nivel;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

    assign aperto = nivel & ~nivel_ant;

    always_comb begin
        chaves_ext = '0;
        chaves_ext[LARGURA_CHAVES-1:0] = chaves_s2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado         <= OCIOSO;
            SWR            <= '0;
            entrada_valida <= 1'b0;
        end else begin
            estado         <= prox_estado;
            entrada_valida <= captura;
            if (captura) SWR <= chaves_ext;
        end
    end

    // A dropped request always wins over a press, so an aborted IN never captures.
    always_comb begin
        prox_estado = estado;
        captura     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (pedido_entrada)
                    prox_estado = nivel ? AGUARDA_SOLTURA : AGUARDA_APERTO;
            end
            AGUARDA_SOLTURA: begin
                if (!pedido_entrada)
                    prox_estado = OCIOSO;
                else if (!nivel)
                    prox_estado = AGUARDA_APERTO;
            end
            AGUARDA_APERTO: begin
                if (!pedido_entrada) begin
                    prox_estado = OCIOSO;
                end else if (aperto) begin
                    prox_estado = CONCLUIDO;
                    captura     = 1'b1;
                end
            end
            CONCLUIDO: begin
                if (!pedido_entrada)
                    prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    assign espera = pedido_entrada & (estado != CONCLUIDO) & ~reset;

endmodule

// File: tb/tb_unidade_entrada.sv
// Directed bench for unidade_entrada: capture scoreboard plus cycle-level stall/pulse checks.
module tb_unidade_entrada;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] chaves;
    logic        botao_enter;
    logic        pedido_entrada;
    logic [31:0] SWR;
    logic        espera;
    logic        entrada_valida;

    int n_checks = 0;
    int n_fail   = 0;
    int pulsos   = 0;
    logic [31:0] esperado_q[$];

    unidade_entrada #(.DEBOUNCE_CICLOS(4), .LARGURA_CHAVES(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .chaves         (chaves),
        .botao_enter    (botao_enter),
        .pedido_entrada (pedido_entrada),
        .SWR            (SWR),
        .espera         (espera),
        .entrada_valida (entrada_valida)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change 1 ns after the edge.
    task automatic ciclos(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Sample at the falling edge following the next rising edge.
    task automatic borda_e_amostra();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic aperta(input int n);
        botao_enter = 1'b1;
        ciclos(n);
        botao_enter = 1'b0;
    endtask

    // Scoreboard: each pulse must match the oldest pending capture.
    always @(negedge clock) begin
        if (!reset && entrada_valida) begin
            pulsos++;
            if (esperado_q.size() == 0) begin
                chk("pulso_inesperado", SWR, 32'hDEAD_BEEF);
            end else begin
                chk("swr_na_captura", SWR, esperado_q.pop_front());
            end
        end
    end

    initial begin
        int p0;
        // 1: reset with switches and button high, pedido high
        reset = 1'b1; chaves = 16'hFFFF; botao_enter = 1'b1; pedido_entrada = 1'b1;
        for (int k = 0; k < 4; k++) begin
            borda_e_amostra();
            chk("reset_swr", SWR, 32'h0);
            chk("reset_espera", {31'b0, espera}, 32'h0);
            chk("reset_valida", {31'b0, entrada_valida}, 32'h0);
        end
        @(posedge clock); #1;
        reset = 1'b0; botao_enter = 1'b0; pedido_entrada = 1'b0;
        ciclos(8);

        // 2: clean press; capture at E6, pulse exactly one cycle
        pedido_entrada = 1'b1; chaves = 16'hA5C3; botao_enter = 1'b1;
        #1;
        chk("t2_espera_comb", {31'b0, espera}, 32'h1);
        esperado_q.push_back(32'h0000A5C3);
        p0 = pulsos;
        for (int k = 0; k < 10; k++) begin
            borda_e_amostra();
            chk($sformatf("t2_espera_E%0d", k), {31'b0, espera}, (k < 6) ? 32'h1 : 32'h0);
            chk($sformatf("t2_valida_E%0d", k), {31'b0, entrada_valida}, (k == 6) ? 32'h1 : 32'h0);
        end
        #1; botao_enter = 1'b0;
        ciclos(8);
        chk("t2_swr", SWR, 32'h0000A5C3);
        chk("t2_pulsos", pulsos - p0, 1);
        pedido_entrada = 1'b0;
        ciclos(8);

        // 3: 3-cycle glitch is ignored, following press captures
        pedido_entrada = 1'b1; chaves = 16'h1234;
        p0 = pulsos;
        ciclos(2);
        aperta(3);
        ciclos(10);
        @(negedge clock);
        chk("t3_glitch_swr", SWR, 32'h0000A5C3);
        chk("t3_glitch_espera", {31'b0, espera}, 32'h1);
        chk("t3_glitch_pulsos", pulsos - p0, 0);
        @(posedge clock); #1;
        esperado_q.push_back(32'h00001234);
        aperta(10);
        ciclos(2);
        chk("t3_swr", SWR, 32'h00001234);
        chk("t3_pulsos", pulsos - p0, 1);
        pedido_entrada = 1'b0;
        ciclos(8);

        // 4: button already held when pedido rises
        botao_enter = 1'b1;
        ciclos(8);
        chaves = 16'h0001; pedido_entrada = 1'b1;
        p0 = pulsos;
        ciclos(8);
        chk("t4_segurado_espera", {31'b0, espera}, 32'h1);
        chk("t4_segurado_swr", SWR, 32'h00001234);
        botao_enter = 1'b0;
        ciclos(8);
        chk("t4_solto_pulsos", pulsos - p0, 0);
        chaves = 16'h0002;
        esperado_q.push_back(32'h00000002);
        aperta(10);
        ciclos(2);
        chk("t4_swr", SWR, 32'h00000002);
        chk("t4_pulsos", pulsos - p0, 1);
        pedido_entrada = 1'b0;
        ciclos(8);

        // 5: abort in AGUARDA_APERTO, later press does nothing
        pedido_entrada = 1'b1; chaves = 16'h0BAD;
        p0 = pulsos;
        ciclos(3);
        pedido_entrada = 1'b0;
        aperta(10);
        ciclos(8);
        chk("t5_swr", SWR, 32'h00000002);
        chk("t5_pulsos", pulsos - p0, 0);
        chk("t5_espera", {31'b0, espera}, 32'h0);

        // 6: back-to-back INs with pedido low for one cycle
        p0 = pulsos;
        chaves = 16'h00FF; pedido_entrada = 1'b1;
        esperado_q.push_back(32'h000000FF);
        aperta(10);
        ciclos(8);
        chk("t6a_swr", SWR, 32'h000000FF);
        pedido_entrada = 1'b0;
        ciclos(1);
        pedido_entrada = 1'b1; chaves = 16'hFF00;
        esperado_q.push_back(32'h0000FF00);
        aperta(10);
        ciclos(8);
        chk("t6b_swr", SWR, 32'h0000FF00);
        chk("t6_pulsos", pulsos - p0, 2);
        // pedido held high: a further press must not recapture
        chaves = 16'h7777;
        aperta(10);
        ciclos(8);
        chk("t6c_swr", SWR, 32'h0000FF00);
        chk("t6c_pulsos", pulsos - p0, 2);
        chk("t6c_espera", {31'b0, espera}, 32'h0);
        pedido_entrada = 1'b0;
        ciclos(4);
        chk("fila_vazia", esperado_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
